// File: rtl/thresh_counter_pkg.sv
// Shared types for the threshold counter bank: channel FSM states, clear modes
// and the timer sizing helper.
package thresh_counter_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    OVER  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef enum logic {
    AUTO_CLR = 1'b0,
    EXT_CLR  = 1'b1
  } mode_e;

  function automatic int timer_width(input int clr_delay);
    int w;
    w = $clog2(clr_delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/thresh_counter_bank_if.sv
// Bank-level control/status bundle; master drives requests, slave returns
// registered counts and flags. No handshake: every cycle is a new sample.
interface thresh_counter_bank_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       inc_i;
  logic [CHANNELS-1:0]       clr_i;
  logic [WIDTH-1:0]          threshold_i;
  logic                      mode_i;
  logic                      viol_clr_i;
  logic [CHANNELS*WIDTH-1:0] count_o;
  logic [CHANNELS-1:0]       over_o;
  logic [CHANNELS-1:0]       viol_o;

  modport master (
    output inc_i, clr_i, threshold_i, mode_i, viol_clr_i,
    input  count_o, over_o, viol_o
  );

  modport slave (
    input  inc_i, clr_i, threshold_i, mode_i, viol_clr_i,
    output count_o, over_o, viol_o
  );
endinterface

// File: rtl/thresh_counter_chan.sv
// One counter channel: counts until it exceeds the threshold, then waits
// CLR_DELAY edges and either self-clears or flags a sticky timeout. 1-cycle latency.
module thresh_counter_chan
  import thresh_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CLR_DELAY = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_threshold,
  input  logic             i_mode,
  input  logic             i_viol_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_over,
  output logic             o_viol
);

  localparam int            TW         = timer_width(CLR_DELAY);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLR_DELAY - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_count_inc;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_nxt;
  logic             r_viol;
  logic             w_viol_set;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= COUNT;
      r_count <= '0;
      r_timer <= '0;
      r_viol  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_timer <= w_timer_nxt;
      // A new violation beats a simultaneous clear of the sticky flag.
      r_viol  <= w_viol_set | (r_viol & ~i_viol_clr);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_timer_nxt = r_timer;
    w_viol_set  = 1'b0;
    w_count_inc = r_count + 1'b1;
    if (i_clr) begin
      w_state_nxt = COUNT;
      w_count_nxt = '0;
      w_timer_nxt = '0;
    end else begin
      case (r_state)
        COUNT: begin
          if (i_inc) begin
            w_count_nxt = w_count_inc;
            if (w_count_inc > i_threshold) begin
              w_state_nxt = OVER;
              w_timer_nxt = TIMER_LOAD;
            end
          end
        end
        OVER: begin
          if (r_timer == '0) begin
            if (mode_e'(i_mode) == AUTO_CLR) begin
              w_state_nxt = COUNT;
              w_count_nxt = '0;
            end else begin
              w_state_nxt = HOLD;
              w_viol_set  = 1'b1;
            end
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        HOLD:    w_state_nxt = HOLD;
        default: w_state_nxt = COUNT;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_over  = (r_state != COUNT);
  assign o_viol  = r_viol;

endmodule

// File: rtl/thresh_counter_bank.sv
// Bank of CHANNELS independent threshold counters sharing threshold, mode and
// violation-clear inputs. Outputs registered, 1-cycle latency, no backpressure.
module thresh_counter_bank
  import thresh_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 4,
  parameter int CLR_DELAY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       inc_i,
  input  logic [CHANNELS-1:0]       clr_i,
  input  logic [WIDTH-1:0]          threshold_i,
  input  logic                      mode_i,
  input  logic                      viol_clr_i,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       over_o,
  output logic [CHANNELS-1:0]       viol_o
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    thresh_counter_chan #(
      .WIDTH     (WIDTH),
      .CLR_DELAY (CLR_DELAY)
    ) u_chan (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_inc       (inc_i[g]),
      .i_clr       (clr_i[g]),
      .i_threshold (threshold_i),
      .i_mode      (mode_i),
      .i_viol_clr  (viol_clr_i),
      .o_count     (count_o[g*WIDTH +: WIDTH]),
      .o_over      (over_o[g]),
      .o_viol      (viol_o[g])
    );
  end

endmodule

// File: tb/tb_thresh_counter_bank.sv
// Directed bench: stimulus pushes hand-computed post-edge snapshots into a
// queue; a monitor pops one per edge and compares count/over/viol.
module tb_thresh_counter_bank;

  typedef struct {
    logic [15:0] c;
    logic [3:0]  o;
    logic [3:0]  v;
    string       nm;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_chk;
  int   n_fail;
  int   e_c[4];
  bit   e_o[4];
  bit   e_v[4];

  thresh_counter_bank_if #(.WIDTH(4), .CHANNELS(4)) bus ();

  thresh_counter_bank #(.WIDTH(4), .CHANNELS(4), .CLR_DELAY(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (bus.inc_i),
    .clr_i       (bus.clr_i),
    .threshold_i (bus.threshold_i),
    .mode_i      (bus.mode_i),
    .viol_clr_i  (bus.viol_clr_i),
    .count_o     (bus.count_o),
    .over_o      (bus.over_o),
    .viol_o      (bus.viol_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input string nm);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.c[k*4 +: 4] = 4'(e_c[k]);
      e.o[k]        = e_o[k];
      e.v[k]        = e_v[k];
    end
    e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 4; k++) begin
      e_c[k] = 0;
      e_o[k] = 1'b0;
      e_v[k] = 1'b0;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if (bus.count_o !== e.c) begin
          n_fail++;
          $display("FAIL %s count_o got %h expected %h", e.nm, bus.count_o, e.c);
        end
        n_chk++;
        if (bus.over_o !== e.o) begin
          n_fail++;
          $display("FAIL %s over_o got %b expected %b", e.nm, bus.over_o, e.o);
        end
        n_chk++;
        if (bus.viol_o !== e.v) begin
          n_fail++;
          $display("FAIL %s viol_o got %b expected %b", e.nm, bus.viol_o, e.v);
        end
      end
    end
  end

  initial begin : stim
    n_chk  = 0;
    n_fail = 0;
    rst_n           = 1'b0;
    bus.inc_i       = '0;
    bus.clr_i       = '0;
    bus.threshold_i = 4'd8;
    bus.mode_i      = 1'b0;
    bus.viol_clr_i  = 1'b0;
    clear_exp();
    tick("reset0");
    tick("reset1");

    // Auto-clear: cross at 9, zero two edges later, then resume counting
    rst_n     = 1'b1;
    bus.inc_i = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      e_c[0] = i;
      e_o[0] = (i == 9);
      tick("s1_count");
    end
    tick("s1_over_wait");
    e_c[0] = 0; e_o[0] = 1'b0;
    tick("s1_autoclr");
    e_c[0] = 1; tick("s1_resume1");
    e_c[0] = 2; tick("s1_resume2");

    // External-clear timeout; set wins against same-edge viol_clr
    bus.inc_i = 4'b0000;
    bus.clr_i = 4'b0001;
    e_c[0] = 0;
    tick("s2_preclr");
    bus.clr_i  = 4'b0000;
    bus.mode_i = 1'b1;
    bus.inc_i  = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      e_c[0] = i;
      e_o[0] = (i == 9);
      tick("s2_count");
    end
    tick("s2_over_wait");
    bus.viol_clr_i = 1'b1;
    e_v[0] = 1'b1;
    tick("s2_viol_set");
    bus.viol_clr_i  = 1'b0;
    bus.threshold_i = 4'd15;
    tick("s2_hold");
    bus.threshold_i = 4'd8;
    bus.inc_i = 4'b0000;
    bus.clr_i = 4'b0001;
    e_c[0] = 0; e_o[0] = 1'b0;
    tick("s2_clr_hold");
    bus.clr_i      = 4'b0000;
    bus.viol_clr_i = 1'b1;
    e_v[0] = 1'b0;
    tick("s2_viol_clr");
    bus.viol_clr_i = 1'b0;

    // Clear one edge after crossing, then clear on the expiry edge
    bus.inc_i = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      e_c[0] = i;
      e_o[0] = (i == 9);
      tick("s3_count");
    end
    bus.clr_i = 4'b0001;
    e_c[0] = 0; e_o[0] = 1'b0;
    tick("s3_clr_early");
    bus.clr_i = 4'b0000;
    bus.inc_i = 4'b0000;
    tick("s3_idle1");
    tick("s3_idle2");
    bus.inc_i = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      e_c[0] = i;
      e_o[0] = (i == 9);
      tick("s3b_count");
    end
    tick("s3b_over_wait");
    bus.clr_i = 4'b0001;
    e_c[0] = 0; e_o[0] = 1'b0;
    tick("s3b_clr_expiry");
    bus.clr_i = 4'b0000;
    bus.inc_i = 4'b0000;
    tick("s3b_after");

    // Mode is only looked at on the expiry edge
    bus.inc_i = 4'b0001;
    for (int i = 1; i <= 9; i++) begin
      e_c[0] = i;
      e_o[0] = (i == 9);
      tick("s4_count");
    end
    tick("s4_over_wait");
    bus.mode_i = 1'b0;
    e_c[0] = 0; e_o[0] = 1'b0;
    tick("s4_mode_at_expiry");

    // Threshold at max: free wrap, never over
    bus.threshold_i = 4'd15;
    for (int i = 1; i <= 17; i++) begin
      e_c[0] = i % 16;
      tick("s5_wrap");
    end
    bus.inc_i = 4'b0000;

    // Independence, inc+clr priority, reset mid-OVER
    bus.clr_i = 4'b1111;
    clear_exp();
    tick("s6_clrall");
    bus.clr_i       = 4'b0000;
    bus.threshold_i = 4'd10;
    bus.inc_i       = 4'b0110;
    for (int i = 1; i <= 5; i++) begin
      e_c[1] = i;
      e_c[2] = i;
      tick("s6_count");
    end
    bus.inc_i = 4'b1110;
    bus.clr_i = 4'b0010;
    e_c[1] = 0; e_c[2] = 6; e_c[3] = 1;
    tick("s6_inc_clr");
    bus.clr_i = 4'b0000;
    bus.inc_i = 4'b1100;
    for (int i = 7; i <= 11; i++) begin
      e_c[2] = i;
      e_o[2] = (i == 11);
      e_c[3] = i - 5;
      tick("s6_ch2_ch3");
    end
    rst_n = 1'b0;
    clear_exp();
    tick("s6_reset_over");
    rst_n = 1'b1;
    e_c[2] = 1; e_c[3] = 1;
    tick("s6_after_reset");
    bus.inc_i = 4'b0000;

    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
